// File: rtl/add_sub_rr_arbiter.sv
// add_sub_rr_arbiter: 4-way round-robin grant into a one-cycle N-bit add/sub; ports clk, rst, req_valid/ready/a/b/opcode in, rsp_valid/ready/id/result/carry out, busy
module add_sub_rr_arbiter #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  output logic [3:0]     req_ready,
  input  logic [4*N-1:0] req_a,
  input  logic [4*N-1:0] req_b,
  input  logic [3:0]     req_opcode,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_id,
  output logic [N-1:0]   rsp_result,
  output logic           rsp_carry,
  output logic           busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2;
  logic [1:0]   state, ptr, g, id_q;
  logic [N-1:0] a_q, b_q;
  logic         op_q;
  always_comb begin
    g = ptr;
    for (int k = 3; k >= 0; k--)
      if (req_valid[ptr + 2'(k)]) g = ptr + 2'(k);
  end
  assign req_ready = (!rst && state == IDLE && |req_valid) ? 4'b0001 << g : 4'b0000;
  assign busy = !rst && state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= '0;
    end else
      case (state)
        IDLE: if (|req_valid) begin
          a_q   <= req_a[g*N +: N];
          b_q   <= req_b[g*N +: N];
          op_q  <= req_opcode[g];
          id_q  <= g;
          ptr   <= g + 2'd1;
          state <= EXEC;
        end
        EXEC: begin
          {rsp_carry, rsp_result} <= {1'b0, a_q} + {1'b0, b_q ^ {N{op_q}}} + (N+1)'(op_q);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
